// File: rtl/clock_1_2_pkg.sv
// Shared helpers for clock-divider blocks: counter sizing and the legal-period check.
package clock_1_2_pkg;

    function automatic int cnt_width(input int period);
        return (period <= 2) ? 1 : $clog2(period);
    endfunction

    // Divider periods must split evenly into two half-rate clocks with 50 % duty.
    function automatic bit period_is_legal(input int period);
        return (period >= 4) && ((period % 4) == 0);
    endfunction

endpackage

// File: rtl/clock_1_2_phase_counter.sv
// Modulo-N phase counter with synchronous active-high reset.
module phase_counter #(
    parameter int modulus = 8,
    parameter int width   = 3
) (
    input  logic             clock,
    input  logic             reset,
    output logic [width-1:0] cnt
);

    localparam logic [width-1:0] last = width'(modulus - 1);

    logic [width-1:0] cnt_d;
    logic [width-1:0] cnt_q;

    always_comb begin
        cnt_d = (cnt_q == last) ? '0 : cnt_q + width'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/clock_1_2.sv
// Divided-clock generator: clock_1 at period_1, clock_2 at twice that rate,
// plus one-cycle rise strobes, all registered from a shared phase counter.
module clock_1_2
    import clock_1_2_pkg::*;
#(
    parameter int period_1 = 8
) (
    input  logic clock,
    input  logic reset,
    output logic clock_1,
    output logic clock_2,
    output logic tick_1,
    output logic tick_2
);

    localparam int period_2 = period_1 / 2;
    localparam int cnt_w    = cnt_width(period_1);

    localparam logic [cnt_w-1:0] half_1 = cnt_w'(period_1 / 2);
    localparam logic [cnt_w-1:0] per_2  = cnt_w'(period_2);
    localparam logic [cnt_w-1:0] half_2 = cnt_w'(period_2 / 2);

    if (!period_is_legal(period_1)) begin : g_illegal_period
        $error("clock_1_2: period_1 must be >= 4 and a multiple of 4");
    end

    logic [cnt_w-1:0] cnt;
    logic [cnt_w-1:0] cnt_mod;

    logic clock_1_d, clock_2_d, tick_1_d, tick_2_d;
    logic clock_1_q, clock_2_q, tick_1_q, tick_2_q;

    phase_counter #(
        .modulus (period_1),
        .width   (cnt_w)
    ) u_phase_counter (
        .clock (clock),
        .reset (reset),
        .cnt   (cnt)
    );

    // cnt never exceeds 2*period_2-1, so one conditional subtract gives cnt mod period_2.
    always_comb begin
        cnt_mod   = (cnt >= per_2) ? cnt - per_2 : cnt;
        clock_1_d = (cnt < half_1);
        clock_2_d = (cnt_mod < half_2);
        tick_1_d  = (cnt == '0);
        tick_2_d  = (cnt_mod == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clock_1_q <= 1'b0;
            clock_2_q <= 1'b0;
            tick_1_q  <= 1'b0;
            tick_2_q  <= 1'b0;
        end else begin
            clock_1_q <= clock_1_d;
            clock_2_q <= clock_2_d;
            tick_1_q  <= tick_1_d;
            tick_2_q  <= tick_2_d;
        end
    end

    assign clock_1 = clock_1_q;
    assign clock_2 = clock_2_q;
    assign tick_1  = tick_1_q;
    assign tick_2  = tick_2_q;

endmodule

// File: tb/tb_clock_1_2.sv
// Scoreboard bench for clock_1_2 at period_1 = 8, 4 and 16 driven from one shared reset.
module tb_clock_1_2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic c1_p8,  c2_p8,  t1_p8,  t2_p8;
    logic c1_p4,  c2_p4,  t1_p4,  t2_p4;
    logic c1_p16, c2_p16, t1_p16, t2_p16;

    int checks   = 0;
    int failures = 0;
    int edge_no  = 0;
    int since_release = 0;

    logic [3:0] exp_q8[$];
    logic [3:0] exp_q4[$];
    logic [3:0] exp_q16[$];

    always #5 clock = ~clock;

    clock_1_2 #(.period_1(8)) dut_p8 (
        .clock(clock), .reset(reset),
        .clock_1(c1_p8), .clock_2(c2_p8), .tick_1(t1_p8), .tick_2(t2_p8)
    );

    clock_1_2 #(.period_1(4)) dut_p4 (
        .clock(clock), .reset(reset),
        .clock_1(c1_p4), .clock_2(c2_p4), .tick_1(t1_p4), .tick_2(t2_p4)
    );

    clock_1_2 #(.period_1(16)) dut_p16 (
        .clock(clock), .reset(reset),
        .clock_1(c1_p16), .clock_2(c2_p16), .tick_1(t1_p16), .tick_2(t2_p16)
    );

    // Expected {clock_1, clock_2, tick_1, tick_2} on the k-th edge after reset release.
    function automatic logic [3:0] model(input int period, input int k);
        int phase;
        int half_period;
        if (k == 0) return 4'b0000;
        half_period = period / 2;
        phase = (k - 1) % period;
        return {phase < half_period,
                (phase % half_period) < (half_period / 2),
                phase == 0,
                (phase % half_period) == 0};
    endfunction

    task automatic apply_stimulus(input logic rst);
        reset = rst;
        @(posedge clock);
        edge_no++;
        since_release = rst ? 0 : since_release + 1;
        exp_q8.push_back(model(8, since_release));
        exp_q4.push_back(model(4, since_release));
        exp_q16.push_back(model(16, since_release));
        #1;
    endtask

    task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] req);
        string sig_names[4];
        sig_names = '{"tick_2", "tick_1", "clock_2", "clock_1"};
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (act[b] !== req[b]) begin
                failures++;
                $display("[TB] FAIL %s %s edge=%0d actual=%b required=%b",
                         name, sig_names[b], edge_no, act[b], req[b]);
            end
        end
    endtask

    // Monitor: every edge produces an output word per DUT, compared half a cycle later.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q8.size() > 0)  check_output("p8",  {c1_p8,  c2_p8,  t1_p8,  t2_p8},  exp_q8.pop_front());
            if (exp_q4.size() > 0)  check_output("p4",  {c1_p4,  c2_p4,  t1_p4,  t2_p4},  exp_q4.pop_front());
            if (exp_q16.size() > 0) check_output("p16", {c1_p16, c2_p16, t1_p16, t2_p16}, exp_q16.pop_front());
        end
    end

    initial begin
        int burst;
        #1;
        // Reset held for several edges, then a long free run spanning wraps.
        repeat (3) apply_stimulus(1'b1);
        repeat (40) apply_stimulus(1'b0);

        // Reset from a known mid-period phase (counter at 5 for period 8).
        apply_stimulus(1'b1);
        repeat (5) apply_stimulus(1'b0);
        apply_stimulus(1'b1);
        repeat (20) apply_stimulus(1'b0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                burst = $urandom_range(1, 3);
                repeat (burst) apply_stimulus(1'b1);
            end else begin
                apply_stimulus(1'b0);
            end
        end

        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (exp_q8.size() != 0 || exp_q4.size() != 0 || exp_q16.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain pending actual=%0d required=0",
                     exp_q8.size() + exp_q4.size() + exp_q16.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_1_2.md
# clock_1_2

Divided-clock generator: from the single system clock it produces two phase-aligned 50 %-duty square waves, `clock_1` (period `period_1` input cycles) and `clock_2` (exactly twice the frequency of `clock_1`), plus one-cycle rise strobes for each. It sits at the top of serial-line blocks such as the NRZ-to-Manchester encoder. Those blocks take `clock_2` as the bit-half clock, and `clock_1` is the bit-rate reference the stimulus aligns to. All outputs are registered and glitch-free.

## Interface
Parameters:
- `period_1`, default 8: `clock_1` period in input clock cycles. Must be ≥ 4 and a multiple of 4; any other value is an elaboration error.
- `period_2` (derived localparam) = `period_1`/2: `clock_2` period in input cycles.

Ports (one clock; reset is synchronous and active-high):
- `clock` input, 1 bit: system clock; all state updates on its rising edge.
- `reset` input, 1 bit: synchronous active-high reset.
- `clock_1` output, 1 bit: divided clock, period `period_1`, 50 % duty.
- `clock_2` output, 1 bit: divided clock, period `period_2`, 50 % duty.
- `tick_1` output, 1 bit: one-cycle pulse, high in the same cycle `clock_1` is high for its first cycle of each period.
- `tick_2` output, 1 bit: one-cycle pulse, same rule for `clock_2`.

## Operation
- Internal phase counter `cnt`, width clog2(`period_1`), counts 0 … `period_1`−1 and wraps to 0.
- Registered output decode from the current `cnt`:
  - `clock_1` ← (`cnt` < `period_1`/2)
  - `clock_2` ← ((`cnt` mod `period_2`) < `period_2`/2)
  - `tick_1` ← (`cnt` == 0)
  - `tick_2` ← ((`cnt` mod `period_2`) == 0)
- Rising edges of `clock_1` always coincide with a rising edge of `clock_2`. The falling edge of `clock_1` coincides with the second `clock_2` rising edge of the period.
- No enable input: the generator free-runs whenever `reset` is low.

## Timing
- While `reset` is high, at each rising edge: `cnt` ← 0 and all four outputs ← 0. This holds regardless of the current phase, including mid-period.
- First edge after `reset` deasserts: `clock_1`, `clock_2`, `tick_1`, `tick_2` all ← 1; `cnt` ← 1. That is one cycle of output latency from the counter.
- With `period_1` = 8, counting edges after reset release from 1:
  - `clock_1`: high on edges 1–4, low on edges 5–8, repeat.
  - `clock_2`: high on edges 1–2, low 3–4, high 5–6, low 7–8.
  - `tick_1` high on edges 1, 9, 17 …
  - `tick_2` high on edges 1, 5, 9 …
- Wrap: at `cnt` = `period_1`−1 the next value is 0. No dropped or stretched cycle across the wrap.
- Reset asserted mid-operation: outputs reach 0 on the next edge. On release the sequence restarts exactly as from power-up.

## Structure
- Shared package: a function computing counter width from `period_1`, and the legality check (multiple of 4, ≥ 4) reused by other clock-divider blocks.
- Single module. An optional sub-module `phase_counter` (modulo-N counter with synchronous reset) is natural and reusable; the output decode stays in `clock_1_2`.
- Downstream logic should prefer `tick_1`/`tick_2` as clock enables on `clock`. Using `clock_1`/`clock_2` as real clocks is a simulation/legacy convenience.

## Test plan
- Reset hold: assert `reset` for 3 cycles at `period_1` = 8 → all outputs 0 on every edge during reset.
- Steady state, `period_1` = 8: release reset and run 32 cycles → `clock_1` pattern 11110000, `clock_2` 11001100, `tick_1` at edges 1/9/17/25, `tick_2` every 4 edges starting at 1.
- Wrap-around continuity: over 3 consecutive periods → `clock_1` high time exactly 4 and low time exactly 4 each period; no glitch at `cnt` 7→0.
- Mid-period reset: assert `reset` for 1 cycle at `cnt` = 5 → next edge all outputs 0; after release, edge 1 has all outputs 1 again.
- Minimum size, `period_1` = 4 → `clock_1` 1100, `clock_2` 1010, `tick_2` every 2 edges.
- Larger size, `period_1` = 16 → `clock_1` high 8 / low 8, `clock_2` high 4 / low 4. An illegal `period_1` = 10 must fail elaboration.
